// File: rtl/ltc2324_rx_if.sv
// Bundle between the LTC2324 timing generator / SDO pins and the receiver.
// Latency: none (wires only).
// Backpressure: none; the ADC free-runs, and the receiver flags bad frames instead of stalling.
interface ltc2324_rx_if;
  logic        rx_start;
  logic        sck_gate;
  logic        data_latch;
  logic [3:0]  sdo;
  logic [15:0] ch0;
  logic [15:0] ch1;
  logic [15:0] ch2;
  logic [15:0] ch3;
  logic        data_valid;
  logic        frame_err;
  logic [15:0] frame_cnt;

  // Timing generator / pin side: drives the frame controls and serial data.
  modport master (
    output rx_start, sck_gate, data_latch, sdo,
    input  ch0, ch1, ch2, ch3, data_valid, frame_err, frame_cnt
  );

  // Receiver side.
  modport slave (
    input  rx_start, sck_gate, data_latch, sdo,
    output ch0, ch1, ch2, ch3, data_valid, frame_err, frame_cnt
  );
endinterface

// File: rtl/ltc2324_rx.sv
// Deserialises the four LTC2324 SDO lanes, MSB first, into per-channel samples.
// Latency: ch*/data_valid update one clk after the data_latch rising edge arrives.
// Backpressure: none; aborted or short frames pulse frame_err and are dropped.
module ltc2324_rx #(
  parameter int BITS        = 16,
  parameter int CAPTURE_DLY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  ltc2324_rx_if.slave rx_if
);
  localparam logic [4:0] BITS_L = 5'(BITS);
  localparam logic [4:0] LAST_L = 5'(BITS - 1);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_start_q;
  logic                 r_latch_q;
  logic                 w_start_edge;
  logic                 w_latch_edge;
  logic                 w_gate_d;
  logic                 w_arm;
  logic                 w_shift;
  logic                 w_err;
  logic                 w_good;
  logic [4:0]           r_bit_cnt;
  logic [3:0][BITS-1:0] r_lane;
  logic [3:0][15:0]     r_ch;
  logic                 r_data_valid;
  logic                 r_frame_err;
  logic [15:0]          r_frame_cnt;

  // Current input vs. one-cycle-old copy, so a multi-cycle pulse is one event
  // and the latch edge is acted on in the cycle it arrives.
  assign w_start_edge = rx_if.rx_start & ~r_start_q;
  assign w_latch_edge = rx_if.data_latch & ~r_latch_q;

  // Remember the previous level of the two timing-generator strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q <= 1'b0;
      r_latch_q <= 1'b0;
    end else begin
      r_start_q <= rx_if.rx_start;
      r_latch_q <= rx_if.data_latch;
    end
  end

  // The SCK gate is delayed to line up with SDO after the board round trip.
  generate
    if (CAPTURE_DLY == 0) begin : g_no_dly
      assign w_gate_d = rx_if.sck_gate;
    end else begin : g_dly
      logic [CAPTURE_DLY-1:0] r_gate_pipe;

      // Shift the gate through CAPTURE_DLY flops.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_gate_pipe <= '0;
        end else begin
          r_gate_pipe[0] <= rx_if.sck_gate;
          for (int k = 1; k < CAPTURE_DLY; k++) begin
            r_gate_pipe[k] <= r_gate_pipe[k-1];
          end
        end
      end

      assign w_gate_d = r_gate_pipe[CAPTURE_DLY-1];
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath controls; rx_start outranks everything else.
  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_shift     = 1'b0;
    w_err       = 1'b0;
    w_good      = 1'b0;
    if (w_start_edge) begin
      w_arm       = 1'b1;
      w_err       = (r_state != IDLE);
      w_state_nxt = ARMED;
    end else begin
      case (r_state)
        ARMED, SHIFT: begin
          if (w_latch_edge) begin
            w_err       = 1'b1;
            w_state_nxt = IDLE;
          end else if (w_gate_d && (r_bit_cnt < BITS_L)) begin
            w_shift     = 1'b1;
            w_state_nxt = (r_bit_cnt == LAST_L) ? DONE : SHIFT;
          end
        end
        DONE: begin
          if (w_latch_edge) begin
            w_good      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // Lane shifting, sample hand-off and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt    <= '0;
      r_lane       <= '0;
      r_ch         <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_data_valid <= w_good;
      r_frame_err  <= w_err;
      if (w_arm) begin
        r_bit_cnt <= '0;
        r_lane    <= '0;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + 5'd1;
        for (int i = 0; i < 4; i++) begin
          r_lane[i] <= {r_lane[i][BITS-2:0], rx_if.sdo[i]};
        end
      end
      if (w_good) begin
        for (int i = 0; i < 4; i++) begin
          r_ch[i] <= 16'(r_lane[i]);
        end
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign rx_if.ch0        = r_ch[0];
  assign rx_if.ch1        = r_ch[1];
  assign rx_if.ch2        = r_ch[2];
  assign rx_if.ch3        = r_ch[3];
  assign rx_if.data_valid = r_data_valid;
  assign rx_if.frame_err  = r_frame_err;
  assign rx_if.frame_cnt  = r_frame_cnt;
endmodule
